// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v counters, registered sync/blank.
// Optional macro SYNC_DELAY_EN delays syncs and video_on by SYNC_DELAY clk.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] pix_row,
  output logic [9:0] pix_col,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             tick;
  logic             h_last;
  logic             v_last;
  logic             wrap_q;
  logic             hs_dec;
  logic             vs_dec;
  logic             vo_dec;
  logic             hs_q;
  logic             vs_q;
  logic             vo_q;

  assign tick   = (div_cnt == DIV_LAST);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  assign vo_dec = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_dec = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
  assign vs_dec = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      wrap_q  <= tick && h_last && v_last;
      if (tick) begin
        h_cnt <= h_last ? '0 : h_cnt + 10'd1;
        if (h_last)
          v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end
    end
  end

  // wrap_q marks counters at (0,0); frame_start lines up with pix outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_col     <= '0;
      pix_row     <= '0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      vo_q        <= 1'b0;
    end else begin
      pix_col     <= h_cnt;
      pix_row     <= v_cnt;
      pixel_tick  <= tick;
      frame_start <= wrap_q;
      hs_q        <= hs_dec;
      vs_q        <= vs_dec;
      vo_q        <= vo_dec;
    end
  end

`ifdef SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_sr;
  logic [SYNC_DELAY-1:0] vs_sr;
  logic [SYNC_DELAY-1:0] vo_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_sr <= '1;
      vs_sr <= '1;
      vo_sr <= '0;
    end else begin
      hs_sr[0] <= hs_q;
      vs_sr[0] <= vs_q;
      vo_sr[0] <= vo_q;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
        vo_sr[i] <= vo_sr[i-1];
      end
    end
  end

  assign horiz_sync = hs_sr[SYNC_DELAY-1];
  assign vert_sync  = vs_sr[SYNC_DELAY-1];
  assign video_on   = vo_sr[SYNC_DELAY-1];
`else
  assign horiz_sync = hs_q;
  assign vert_sync  = vs_q;
  assign video_on   = vo_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default line timing plus
// shrunken-timing frames at CLK_DIV=4 and CLK_DIV=1.
module tb_vga_timing_gen;

`ifdef SYNC_DELAY_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [9:0] row_a, col_a, row_s, col_s, row_f, col_f;
  logic hs_a, vs_a, vo_a, pt_a, fs_a;
  logic hs_s, vs_s, vo_s, pt_s, fs_s;
  logic hs_f, vs_f, vo_f, pt_f, fs_f;

  vga_timing_gen dut (
    .clk(clk), .reset_n(reset_n),
    .pix_row(row_a), .pix_col(col_a),
    .horiz_sync(hs_a), .vert_sync(vs_a),
    .video_on(vo_a), .pixel_tick(pt_a),
    .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(4),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clk(clk), .reset_n(reset_n),
    .pix_row(row_s), .pix_col(col_s),
    .horiz_sync(hs_s), .vert_sync(vs_s),
    .video_on(vo_s), .pixel_tick(pt_s),
    .frame_start(fs_s)
  );

  vga_timing_gen #(
    .CLK_DIV(1),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_f (
    .clk(clk), .reset_n(reset_n),
    .pix_row(row_f), .pix_col(col_f),
    .horiz_sync(hs_f), .vert_sync(vs_f),
    .video_on(vo_f), .pixel_tick(pt_f),
    .frame_start(fs_f)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ptv;
    int n_pt, n_hs, n_vo, step_err, hs_fall, vo_fall, col656;
    int prev_col, prev_hs, prev_vo;
    int n_fs, fs1, fs2, n_vs, vs_out;
    int prow, pcol, n_ptf0, n_fsf, fsf1, found;

    // reset state
    repeat (10) @(negedge clk);
    chk("rst_col", col_a, 0);
    chk("rst_row", row_a, 0);
    chk("rst_hs", hs_a, 1);
    chk("rst_vs", vs_a, 1);
    chk("rst_vo", vo_a, 0);
    chk("rst_pt", pt_a, 0);
    chk("rst_fs", fs_a, 0);

    // one default line
    reset_n = 1'b1;
    ptv = '0; n_pt = 0; n_hs = 0; n_vo = 0;
    step_err = 0; hs_fall = -1; vo_fall = -1; col656 = -1;
    prev_col = 0; prev_hs = 1; prev_vo = 0;
    for (int s = 1; s <= 3204; s++) begin
      @(negedge clk);
      if (s <= 4) ptv[s-1] = pt_a;
      if (s == 1) begin
        chk("rel_col", col_a, 0);
        chk("rel_row", row_a, 0);
        chk("rel_hs", hs_a, 1);
        chk("rel_vs", vs_a, 1);
        chk("rel_vo", vo_a, LAG ? 0 : 1);
      end
      if (s == 5) chk("col_step1", col_a, 1);
      if (s <= 3200 && pt_a) n_pt++;
      if (!hs_a) n_hs++;
      if (s <= 3200 && !vo_a) n_vo++;
      if (col_a != prev_col && col_a != (prev_col + 1) % 800)
        step_err++;
      if (col656 < 0 && col_a == 656) col656 = s;
      if (hs_fall < 0 && prev_hs == 1 && !hs_a) hs_fall = s;
      if (vo_fall < 0 && prev_vo == 1 && !vo_a) vo_fall = s;
      if (s == 3200) begin
        chk("line_end_col", col_a, 799);
        chk("line_end_row", row_a, 0);
      end
      if (s == 3201) begin
        chk("wrap_col", col_a, 0);
        chk("wrap_row", row_a, 1);
      end
      prev_col = col_a; prev_hs = hs_a; prev_vo = vo_a;
    end
    chk("first_ticks", ptv, 4'b1000);
    chk("line_ticks", n_pt, 800);
    chk("hs_low_clks", n_hs, 384);
    chk("vo_low_clks", n_vo, 640);
    chk("col_steps", step_err, 0);
    chk("col656_at", col656, 2625);
    chk("hs_fall_at", hs_fall, 2625 + LAG);
    chk("vo_fall_at", vo_fall, 2561 + LAG);

    // small frames at CLK_DIV=4 and CLK_DIV=1
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    n_fs = 0; fs1 = -1; fs2 = -1; n_vs = 0; vs_out = 0;
    prow = 0; pcol = 0; n_ptf0 = 0; n_fsf = 0; fsf1 = -1;
    for (int s = 1; s <= 1300; s++) begin
      @(negedge clk);
      if (fs_s) begin
        n_fs++;
        if (n_fs == 1) fs1 = s;
        if (n_fs == 2) fs2 = s;
        if (n_fs == 1) begin
          chk("fs_row", row_s, 0);
          chk("fs_col", col_s, 0);
          chk("pre_fs_row", prow, 9);
          chk("pre_fs_col", pcol, 14);
        end
      end
      if (s <= 600 && !vs_s) begin
        n_vs++;
        if (row_s != 7 && row_s != 8) vs_out++;
      end
      if (!pt_f) n_ptf0++;
      if (fs_f) begin
        n_fsf++;
        if (fsf1 < 0) fsf1 = s;
      end
      if (s == 1) chk("f_col1", col_f, 0);
      if (s == 2) chk("f_col2", col_f, 1);
      if (s == 15) chk("f_row15", row_f, 0);
      if (s == 16) chk("f_row16", row_f, 1);
      prow = row_s; pcol = col_s;
    end
    chk("fs_count", n_fs, 2);
    chk("fs_first", fs1, 601);
    chk("fs_period", fs2 - fs1, 600);
    chk("vs_low_clks", n_vs, 120);
    chk("vs_outside", vs_out, LAG);
    chk("f_tick_gaps", n_ptf0, 0);
    chk("f_fs_count", n_fsf, 8);
    chk("f_fs_first", fsf1, 151);

    // async reset mid-frame at row 4 col 7
    found = 0;
    for (int s = 0; s < 700 && !found; s++) begin
      @(negedge clk);
      if (row_s == 4 && col_s == 7) found = 1;
    end
    chk("mid_found", found, 1);
    chk("mid_vo", vo_s, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_col", col_s, 0);
    chk("arst_row", row_s, 0);
    chk("arst_hs", hs_s, 1);
    chk("arst_vs", vs_s, 1);
    chk("arst_vo", vo_s, 0);
    chk("arst_pt", pt_s, 0);
    chk("arst_fs", fs_s, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("re_col", col_s, 0);
    chk("re_row", row_s, 0);
    repeat (4) @(negedge clk);
    chk("re_col5", col_s, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
